// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
// Request/result bus of the serial adder controller.
//
// Parameters
//   WIDTH     operand/result width in bits (2..32)
//
// Signals
//   start     request to begin an addition (requester -> controller)
//   a, b      operands, captured with an accepted start
//   carryin   initial carry, captured with an accepted start
//   busy      high while the controller is stepping through the bits
//   done      one-cycle pulse, results valid
//   sum       registered WIDTH-bit result
//   carryout  registered final carry
//   overflow  registered signed overflow
//
// Modports
//   master    requester side (drives start/a/b/carryin)
//   slave     controller side (drives busy/done/sum/carryout/overflow)
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, a, b, carryin,
        input  busy, done, sum, carryout, overflow
    );

    modport slave (
        input  start, a, b, carryin,
        output busy, done, sum, carryout, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder controller. Operands are shifted LSB first through an
// external 1-bit full adder; the returned sum bits are collected in a shift
// register and the returned carry is fed back through a carry flop. After
// WIDTH steps the result, final carry and signed overflow are registered and
// a one-cycle done pulse is issued.
//
// Parameters
//   WIDTH     operand/result width in bits (2..32)
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   reset_n   synchronous active-low reset
//   bus       request/result bus (slave side), see serial_adder_ctrl_if
//   fa_a      operand A bit to the external full adder
//   fa_b      operand B bit to the external full adder
//   fa_cin    carry to the external full adder
//   fa_sum    sum bit from the external full adder (combinational)
//   fa_cout   carry out from the external full adder (combinational)
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_adder_ctrl_if.slave  bus,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    input  logic                fa_sum,
    input  logic                fa_cout
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] sum_sr_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic             carryout_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_sr_next;

    // Sum register shifted right with the fresh adder bit entering at the MSB.
    always_comb begin
        sum_sr_next = WIDTH'({fa_sum, sum_sr_reg} >> 1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            a_sr_reg     <= '0;
            b_sr_reg     <= '0;
            sum_sr_reg   <= '0;
            sum_reg      <= '0;
            count_reg    <= '0;
            carry_reg    <= 1'b0;
            carryout_reg <= 1'b0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_sr_reg   <= bus.a;
                        b_sr_reg   <= bus.b;
                        carry_reg  <= bus.carryin;
                        sum_sr_reg <= '0;
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    // Zero fill: after WIDTH shifts both operand registers
                    // are empty, so fa_a/fa_b are naturally 0 outside RUN.
                    a_sr_reg   <= a_sr_reg >> 1;
                    b_sr_reg   <= b_sr_reg >> 1;
                    sum_sr_reg <= sum_sr_next;
                    count_reg  <= count_reg + CW'(1);
                    if (count_reg == LAST) begin
                        // carry_reg is the carry into the MSB on this step.
                        sum_reg      <= sum_sr_next;
                        carryout_reg <= fa_cout;
                        overflow_reg <= carry_reg ^ fa_cout;
                        // Drop the carry so fa_cin reads 0 once RUN is left.
                        carry_reg    <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
                    end else begin
                        carry_reg <= fa_cout;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign fa_a         = a_sr_reg[0];
    assign fa_b         = b_sr_reg[0];
    assign fa_cin       = carry_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.sum      = sum_reg;
    assign bus.carryout = carryout_reg;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl. Two instances are built: an
// 8-bit one for directed, random, handshake and reset scenarios, and a 4-bit
// one swept over every (a, b, carryin). Each controller drives a gate-level
// full adder modelled with continuous assigns. Expected results come from an
// integer reference model: unsigned sum/carry from a + b + carryin and signed
// overflow from the two's-complement range of the signed sum.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

    logic fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
    logic fa_a4, fa_b4, fa_cin4, fa_sum4, fa_cout4;

    // External structural full adders.
    assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_cout8 = (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8));
    assign fa_sum4  = fa_a4 ^ fa_b4 ^ fa_cin4;
    assign fa_cout4 = (fa_a4 & fa_b4) | (fa_cin4 & (fa_a4 ^ fa_b4));

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8),
        .fa_a    (fa_a8),
        .fa_b    (fa_b8),
        .fa_cin  (fa_cin8),
        .fa_sum  (fa_sum8),
        .fa_cout (fa_cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4),
        .fa_a    (fa_a4),
        .fa_b    (fa_b4),
        .fa_cin  (fa_cin4),
        .fa_sum  (fa_sum4),
        .fa_cout (fa_cout4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by op8 for one 8-bit transaction.
    int         obs_lat;
    int         obs_busy;
    int         obs_done;
    int         obs_idle_fa;
    logic [7:0] obs_fa_a;
    logic [7:0] obs_fa_b;
    logic [7:0] obs_sum;
    logic       obs_co;
    logic       obs_ov;

    // Reference model: plain integer arithmetic on w-bit operands.
    function automatic void ref_add(input int w, input int x, input int y, input int c,
                                    output int s, output int co, output int ov);
        int full;
        int half;
        int t;
        int sx;
        int sy;
        int st;
        full = 1 << w;
        half = full / 2;
        t    = x + y + c;
        s    = t % full;
        co   = t / full;
        sx   = (x >= half) ? x - full : x;
        sy   = (y >= half) ? y - full : y;
        st   = sx + sy + c;
        ov   = (st >= half || st < -half) ? 1 : 0;
    endfunction

    // Launch one 8-bit operation and watch 12 cycles after the accept edge.
    // Operands are scrambled every cycle after acceptance; pulse_at >= 0
    // re-raises start for one cycle during RUN.
    task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                       input int pulse_at);
        obs_lat     = -1;
        obs_busy    = 0;
        obs_done    = 0;
        obs_idle_fa = 0;
        obs_fa_a    = '0;
        obs_fa_b    = '0;
        obs_sum     = '0;
        obs_co      = 1'b0;
        obs_ov      = 1'b0;
        @(negedge clk);
        bus8.start   = 1'b1;
        bus8.a       = xa;
        bus8.b       = xb;
        bus8.carryin = xc;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) bus8.start = 1'b0;
            bus8.a       = 8'($urandom);
            bus8.b       = 8'($urandom);
            bus8.carryin = 1'($urandom);
            if (k == pulse_at) bus8.start = 1'b1;
            if (k == pulse_at + 1) bus8.start = 1'b0;
            if (bus8.busy) obs_busy++;
            if (k < 8) begin
                obs_fa_a[k] = fa_a8;
                obs_fa_b[k] = fa_b8;
            end else if (fa_a8 || fa_b8 || fa_cin8) begin
                obs_idle_fa++;
            end
            if (bus8.done) begin
                obs_done++;
                if (obs_lat < 0) begin
                    obs_lat = k + 1;
                    obs_sum = bus8.sum;
                    obs_co  = bus8.carryout;
                    obs_ov  = bus8.overflow;
                end
            end
        end
        bus8.start = 1'b0;
        $display("op8 a=%h b=%h cin=%b -> sum=%h co=%b ov=%b lat=%0d busy=%0d done=%0d",
                 xa, xb, xc, obs_sum, obs_co, obs_ov, obs_lat, obs_busy, obs_done);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus8.start = 1'b1;   // start coinciding with reset must be ignored
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.carryin = 1'b1;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.carryin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus8.busy, bus8.done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_busy_done: got %b want 00", {bus8.busy, bus8.done});
        end
        n_cmp++;
        if ({bus8.sum, bus8.carryout, bus8.overflow} !== 10'h000) begin
            n_bad++;
            $display("FAIL reset_result: got %h want 000", {bus8.sum, bus8.carryout, bus8.overflow});
        end
        n_cmp++;
        if ({fa_a8, fa_b8, fa_cin8} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_fa: got %b want 000", {fa_a8, fa_b8, fa_cin8});
        end
        n_cmp++;
        if ({bus4.busy, bus4.done, bus4.sum, bus4.carryout, bus4.overflow} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_dut4: got %h want 00",
                     {bus4.busy, bus4.done, bus4.sum, bus4.carryout, bus4.overflow});
        end
        reset_n    = 1'b1;
        bus8.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus8.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_start_ignored: busy got %b want 0", bus8.busy);
        end
        $display("reset done");
    endtask

    task automatic test_directed();
        logic [7:0] va [5] = '{8'h00, 8'hFF, 8'h7F, 8'hA5, 8'h80};
        logic [7:0] vb [5] = '{8'h00, 8'h01, 8'h01, 8'h5A, 8'h80};
        logic       vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int s, co, ov;
        for (int i = 0; i < 5; i++) begin
            op8(va[i], vb[i], vc[i], -1);
            ref_add(8, int'(va[i]), int'(vb[i]), int'(vc[i]), s, co, ov);
            n_cmp++;
            if (obs_lat !== 9) begin
                n_bad++;
                $display("FAIL dir_latency[%0d]: got %0d want 9", i, obs_lat);
            end
            n_cmp++;
            if ({obs_co, obs_sum, obs_ov} !== {1'(co), 8'(s), 1'(ov)}) begin
                n_bad++;
                $display("FAIL dir_result[%0d]: got co=%b sum=%h ov=%b want co=%0d sum=%h ov=%0d",
                         i, obs_co, obs_sum, obs_ov, co, 8'(s), ov);
            end
            n_cmp++;
            if (obs_busy !== 8 || obs_done !== 1) begin
                n_bad++;
                $display("FAIL dir_pulse_len[%0d]: got busy=%0d done=%0d want 8/1",
                         i, obs_busy, obs_done);
            end
            n_cmp++;
            if (obs_fa_a !== va[i] || obs_fa_b !== vb[i] || obs_idle_fa !== 0) begin
                n_bad++;
                $display("FAIL dir_fa_stream[%0d]: got a=%h b=%h idle=%0d want a=%h b=%h idle=0",
                         i, obs_fa_a, obs_fa_b, obs_idle_fa, va[i], vb[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] x, y;
        logic c;
        int s, co, ov;
        for (int i = 0; i < 20; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            c = 1'($urandom);
            op8(x, y, c, -1);
            ref_add(8, int'(x), int'(y), int'(c), s, co, ov);
            n_cmp++;
            if (obs_lat !== 9 || {obs_co, obs_sum, obs_ov} !== {1'(co), 8'(s), 1'(ov)}) begin
                n_bad++;
                $display("FAIL rnd[%0d] a=%h b=%h c=%b: got lat=%0d co=%b sum=%h ov=%b want lat=9 co=%0d sum=%h ov=%0d",
                         i, x, y, c, obs_lat, obs_co, obs_sum, obs_ov, co, 8'(s), ov);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] x, y;
        logic c;
        int s, co, ov;
        x = 8'($urandom);
        y = 8'($urandom);
        c = 1'($urandom);
        op8(x, y, c, 2);
        ref_add(8, int'(x), int'(y), int'(c), s, co, ov);
        n_cmp++;
        if ({obs_co, obs_sum, obs_ov} !== {1'(co), 8'(s), 1'(ov)}) begin
            n_bad++;
            $display("FAIL ignore_start_result: got co=%b sum=%h ov=%b want co=%0d sum=%h ov=%0d",
                     obs_co, obs_sum, obs_ov, co, 8'(s), ov);
        end
        n_cmp++;
        if (obs_lat !== 9 || obs_done !== 1 || obs_busy !== 8) begin
            n_bad++;
            $display("FAIL ignore_start_queue: got lat=%0d done=%0d busy=%0d want 9/1/8",
                     obs_lat, obs_done, obs_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x1, y1, x2, y2;
        logic c1, c2;
        int s1, co1, ov1, s2, co2, ov2;
        int d1, d2, nd, holdbad;
        logic [9:0] r1, r2;
        x1 = 8'($urandom); y1 = 8'($urandom); c1 = 1'($urandom);
        x2 = 8'($urandom); y2 = 8'($urandom); c2 = 1'($urandom);
        ref_add(8, int'(x1), int'(y1), int'(c1), s1, co1, ov1);
        ref_add(8, int'(x2), int'(y2), int'(c2), s2, co2, ov2);
        d1 = -1; d2 = -1; nd = 0; holdbad = 0; r1 = '0; r2 = '0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = x1; bus8.b = y1; bus8.carryin = c1;
        @(posedge clk);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus8.a = x2; bus8.b = y2; bus8.carryin = c2;
            end
            if (k == 10) bus8.start = 1'b0;
            if (bus8.done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = k + 1;
                    r1 = {bus8.carryout, bus8.sum, bus8.overflow};
                end else if (d2 < 0) begin
                    d2 = k + 1;
                    r2 = {bus8.carryout, bus8.sum, bus8.overflow};
                end
            end
            if (k >= 9 && k <= 17 && bus8.sum !== 8'(s1)) holdbad++;
        end
        bus8.start = 1'b0;
        $display("b2b op1 a=%h b=%h c=%b -> %h @%0d ; op2 a=%h b=%h c=%b -> %h @%0d",
                 x1, y1, c1, r1, d1, x2, y2, c2, r2, d2);
        n_cmp++;
        if (nd !== 2 || d1 !== 9 || d2 !== 19) begin
            n_bad++;
            $display("FAIL b2b_timing: got n=%0d d1=%0d d2=%0d want 2/9/19", nd, d1, d2);
        end
        n_cmp++;
        if (r1 !== {1'(co1), 8'(s1), 1'(ov1)}) begin
            n_bad++;
            $display("FAIL b2b_result1: got %h want %h", r1, {1'(co1), 8'(s1), 1'(ov1)});
        end
        n_cmp++;
        if (r2 !== {1'(co2), 8'(s2), 1'(ov2)}) begin
            n_bad++;
            $display("FAIL b2b_result2: got %h want %h", r2, {1'(co2), 8'(s2), 1'(ov2)});
        end
        n_cmp++;
        if (holdbad !== 0) begin
            n_bad++;
            $display("FAIL b2b_sum_hold: got %0d changed cycles want 0", holdbad);
        end
    endtask

    task automatic test_reset_mid_run();
        int s, co, ov, nd, nb;
        logic [7:0] x, y;
        logic c;
        // Leave a nonzero result behind so the clear is visible.
        op8(8'h33, 8'hC4, 1'b1, -1);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = 8'h5C; bus8.b = 8'h71; bus8.carryin = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) bus8.start = 1'b0;
            if (k == 3) reset_n = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if ({bus8.busy, bus8.done, bus8.sum, bus8.carryout, bus8.overflow} !== 12'h000) begin
            n_bad++;
            $display("FAIL midrun_reset_clear: got busy=%b done=%b sum=%h co=%b ov=%b want all 0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carryout, bus8.overflow);
        end
        n_cmp++;
        if ({fa_a8, fa_b8, fa_cin8} !== 3'b000) begin
            n_bad++;
            $display("FAIL midrun_reset_fa: got %b want 000", {fa_a8, fa_b8, fa_cin8});
        end
        reset_n = 1'b1;
        nd = 0; nb = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done) nd++;
            if (bus8.busy) nb++;
        end
        n_cmp++;
        if (nd !== 0 || nb !== 0) begin
            n_bad++;
            $display("FAIL midrun_no_done: got done=%0d busy=%0d cycles want 0/0", nd, nb);
        end
        $display("midrun reset: done=%0d busy=%0d after release", nd, nb);
        x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
        op8(x, y, c, -1);
        ref_add(8, int'(x), int'(y), int'(c), s, co, ov);
        n_cmp++;
        if (obs_lat !== 9 || {obs_co, obs_sum, obs_ov} !== {1'(co), 8'(s), 1'(ov)}) begin
            n_bad++;
            $display("FAIL after_reset_op: got lat=%0d co=%b sum=%h ov=%b want lat=9 co=%0d sum=%h ov=%0d",
                     obs_lat, obs_co, obs_sum, obs_ov, co, 8'(s), ov);
        end
    endtask

    task automatic test_exhaustive4();
        int s, co, ov, lat;
        logic [3:0] gs;
        logic gc, go;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    bus4.start   = 1'b1;
                    bus4.a       = 4'(x);
                    bus4.b       = 4'(y);
                    bus4.carryin = 1'(c);
                    @(posedge clk);
                    lat = -1; gs = '0; gc = 1'b0; go = 1'b0;
                    for (int k = 0; k < 10 && lat < 0; k++) begin
                        @(negedge clk);
                        if (k == 0) bus4.start = 1'b0;
                        if (bus4.done) begin
                            lat = k + 1;
                            gs  = bus4.sum;
                            gc  = bus4.carryout;
                            go  = bus4.overflow;
                        end
                    end
                    bus4.start = 1'b0;
                    ref_add(4, x, y, c, s, co, ov);
                    $display("op4 a=%h b=%h cin=%0d -> sum=%h co=%b ov=%b lat=%0d", x, y, c, gs, gc, go, lat);
                    n_cmp++;
                    if (lat !== 5 || gs !== 4'(s) || gc !== 1'(co) || go !== 1'(ov)) begin
                        n_bad++;
                        $display("FAIL exh4 a=%0d b=%0d c=%0d: got lat=%0d sum=%h co=%b ov=%b want lat=5 sum=%h co=%0d ov=%0d",
                                 x, y, c, lat, gs, gc, go, 4'(s), co, ov);
                    end
                end
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.carryin = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.carryin = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits, legal range 2..32.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 carryin  input  1  initial carry; captured on the accepted start edge.
REQ-008 fa_a  output  1  bit to the external 1-bit full adder, input a.
REQ-009 fa_b  output  1  bit to the external full adder, input b.
REQ-010 fa_cin  output  1  carry to the external full adder.
REQ-011 fa_sum  input  1  sum returned by the external full adder (combinational).
REQ-012 fa_cout  input  1  carryout returned by the external full adder (combinational).
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse; results valid.
REQ-015 sum  output  WIDTH  registered result.
REQ-016 carryout  output  1  registered final carry.
REQ-017 overflow  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-019 IDLE: start=1 at an edge SHALL load a, b into shift registers, carryin into the carry flop, clear the bit counter and the sum shift register, and go to RUN; start=0 stays in IDLE.
REQ-020 RUN: fa_a/fa_b SHALL be the LSB of the A/B shift registers and fa_cin the carry flop, all driven from registers (no combinational path from start, a, b).
REQ-021 RUN, each edge: A/B shift right by one; fa_sum shifts into the sum shift register MSB (register shifts right); carry flop <= fa_cout; counter increments.
REQ-022 On the RUN edge with counter == WIDTH-1, fa_cin SHALL be captured as carry-into-MSB; on that same edge the state goes to DONE and sum/carryout/overflow registers load.
REQ-023 Latency: done SHALL be high in the cycle following the WIDTH-th RUN edge, i.e. WIDTH+1 edges after the start-accepting edge.
REQ-024 DONE SHALL last exactly one cycle and return unconditionally to IDLE; done is high only in DONE.
REQ-025 sum, carryout, overflow SHALL hold their value from DONE until the next result load; they do not change during a subsequent RUN.
REQ-026 start in RUN or DONE SHALL be ignored (not queued); a start held high through DONE is accepted on the first IDLE edge.
REQ-027 Outside RUN, fa_a, fa_b, fa_cin SHALL be 0.
REQ-028 busy SHALL equal (state == RUN).
REQ-029 Arithmetic: {carryout, sum} SHALL equal a + b + carryin modulo 2^(WIDTH+1); no truncation other than WIDTH-bit sum.
REQ-030 Counter width SHALL be ceil(log2(WIDTH))+1 bits; counter does not wrap during a single operation.
REQ-031 Operand inputs changing while busy SHALL NOT affect the operation in progress.

Reset
REQ-032 reset_n=0 at an edge SHALL force IDLE and clear counter, carry flop, shift registers, sum, carryout, overflow, done, busy to 0, regardless of state.
REQ-033 Reset mid-RUN SHALL abort the operation with no done pulse; the first accepted start after reset release behaves as from power-up.
REQ-034 start sampled on the same edge as reset_n=0 SHALL be ignored.

Verification (WIDTH=8, bench instantiates structuralFullAdder as the external adder)
REQ-035 a=0x00, b=0x00, carryin=0 -> done at start edge+9, sum=0x00, carryout=0, overflow=0.
REQ-036 a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, carryout=0, overflow=1.
REQ-037 a=0xA5, b=0x5A, carryin=1 -> sum=0x00, carryout=1, overflow=0; busy high for exactly 8 cycles, done high for exactly 1.
REQ-038 start re-pulsed at RUN cycle 3 with different operands -> ignored, result equals first operation; start held high through DONE -> second operation starts next IDLE edge.
REQ-039 reset_n=0 at RUN cycle 4 -> next cycle IDLE, busy=0, sum/carryout/overflow=0, no done pulse.
REQ-040 WIDTH=4 exhaustive: all 512 (a,b,carryin) -> {carryout,sum} matches a+b+carryin, overflow matches signed-overflow rule.
